// File: rtl/mem_bridge.sv
// mem_bridge: bridges the datapath memory request interface (mem_*) onto a
// 16-bit physical memory port (pmem_*). It handles one transaction at a time.
// A wait counter aborts the transaction when pmem_resp does not arrive within
// TIMEOUT request cycles.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_read, mem_write        request from control, held until mem_resp
//   mem_byte                   1 = byte access, 0 = word access
//   mem_address, mem_wdata     byte address and store data from the datapath
//   mem_rdata                  read data back to the datapath (registered)
//   mem_resp, mem_error        one-cycle completion / timeout-abort pulses
//   pmem_read, pmem_write      physical strobes (registered)
//   pmem_address, pmem_wdata   word-aligned address and lane-replicated data
//   pmem_byte_enable           lane enables, bit1 = [15:8], bit0 = [7:0]
//   pmem_rdata, pmem_resp      physical read data and completion
module mem_bridge #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_error,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Count value at which a REQ edge without pmem_resp aborts.
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    // Only byte writes narrow the lanes; reads always fetch the whole word.
    function automatic logic [1:0] lane_enables(input logic is_write,
                                                input logic is_byte,
                                                input logic addr_lsb);
        logic [1:0] be_s;
        if (is_write && is_byte) begin
            if (addr_lsb) begin
                be_s = 2'b10;
            end else begin
                be_s = 2'b01;
            end
        end else begin
            be_s = 2'b11;
        end
        return be_s;
    endfunction

    // Byte stores replicate the low byte so either lane carries it.
    function automatic logic [15:0] lane_data(input logic is_write,
                                              input logic is_byte,
                                              input logic [15:0] data);
        logic [15:0] d_s;
        if (is_write && is_byte) begin
            d_s = {data[7:0], data[7:0]};
        end else begin
            d_s = data;
        end
        return d_s;
    endfunction

    state_t      state_r, state_next_s;
    logic [7:0]  cnt_r, cnt_next_s;
    logic        op_write_r, op_write_next_s;
    logic        rd_r, rd_next_s;
    logic        wr_r, wr_next_s;
    logic [15:0] addr_r, addr_next_s;
    logic [15:0] wdata_r, wdata_next_s;
    logic [1:0]  be_r, be_next_s;
    logic [15:0] rdata_r, rdata_next_s;
    logic        resp_r, resp_next_s;
    logic        error_r, error_next_s;
    logic        timeout_s;

    assign timeout_s = (cnt_r == LAST_COUNT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; pmem_resp beats a coincident timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_write || mem_read) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (pmem_resp) begin
                    state_next_s = ST_DONE;
                end else if (timeout_s) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            ST_ERR:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and of the wait counter.
    always_comb begin
        cnt_next_s      = cnt_r;
        op_write_next_s = op_write_r;
        rd_next_s       = rd_r;
        wr_next_s       = wr_r;
        addr_next_s     = addr_r;
        wdata_next_s    = wdata_r;
        be_next_s       = be_r;
        rdata_next_s    = rdata_r;
        resp_next_s     = 1'b0;
        error_next_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_write || mem_read) begin
                    // Write wins when both requests are high.
                    op_write_next_s = mem_write;
                    rd_next_s       = ~mem_write;
                    wr_next_s       = mem_write;
                    addr_next_s     = {mem_address[15:1], 1'b0};
                    wdata_next_s    = lane_data(mem_write, mem_byte, mem_wdata);
                    be_next_s       = lane_enables(mem_write, mem_byte, mem_address[0]);
                    cnt_next_s      = 8'd0;
                end else begin
                    rd_next_s = 1'b0;
                    wr_next_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (pmem_resp) begin
                    rd_next_s   = 1'b0;
                    wr_next_s   = 1'b0;
                    resp_next_s = 1'b1;
                    if (!op_write_r) begin
                        rdata_next_s = pmem_rdata;
                    end else begin
                        rdata_next_s = rdata_r;
                    end
                end else if (timeout_s) begin
                    rd_next_s    = 1'b0;
                    wr_next_s    = 1'b0;
                    resp_next_s  = 1'b1;
                    error_next_s = 1'b1;
                    // An aborted read returns zero; writes leave read data alone.
                    if (!op_write_r) begin
                        rdata_next_s = 16'h0000;
                    end else begin
                        rdata_next_s = rdata_r;
                    end
                end else begin
                    cnt_next_s = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                rd_next_s = 1'b0;
                wr_next_s = 1'b0;
            end
            ST_ERR: begin
                rd_next_s = 1'b0;
                wr_next_s = 1'b0;
            end
            default: begin
                rd_next_s = 1'b0;
                wr_next_s = 1'b0;
            end
        endcase
    end

    // Output and counter registers; reset drops strobes without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 8'd0;
            op_write_r <= 1'b0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            addr_r     <= 16'h0000;
            wdata_r    <= 16'h0000;
            be_r       <= 2'b00;
            rdata_r    <= 16'h0000;
            resp_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            op_write_r <= op_write_next_s;
            rd_r       <= rd_next_s;
            wr_r       <= wr_next_s;
            addr_r     <= addr_next_s;
            wdata_r    <= wdata_next_s;
            be_r       <= be_next_s;
            rdata_r    <= rdata_next_s;
            resp_r     <= resp_next_s;
            error_r    <= error_next_s;
        end
    end

    assign pmem_read        = rd_r;
    assign pmem_write       = wr_r;
    assign pmem_address     = addr_r;
    assign pmem_wdata       = wdata_r;
    assign pmem_byte_enable = be_r;
    assign mem_rdata        = rdata_r;
    assign mem_resp         = resp_r;
    assign mem_error        = error_r;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge with TIMEOUT = 4. The bench plays the
// physical memory. For each transaction it predicts the strobe count, the
// lane layout, the error flag and the returned data from the transaction
// parameters alone.
module tb_mem_bridge;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        mem_error;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] model_rdata = 16'h0000;

    mem_bridge #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_byte         (mem_byte),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_resp         (mem_resp),
        .mem_error        (mem_error),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction. delay = REQ cycle (1-based) in which memory answers;
    // 0 or anything beyond TO means memory never answers.
    task automatic run_txn(input logic rd, input logic wr, input logic byt,
                           input logic [15:0] addr, input logic [15:0] wd,
                           input logic [15:0] rdv, input int delay, input logic held);
        logic        is_wr;
        logic        answered;
        logic [15:0] exp_addr;
        logic [15:0] exp_wd;
        logic [1:0]  exp_be;
        int          n_strobe;
        int          seen;
        is_wr    = wr;
        answered = (delay >= 1) && (delay <= TO);
        n_strobe = answered ? delay : TO;
        exp_addr = addr & 16'hFFFE;
        exp_be   = 2'b11;
        exp_wd   = wd;
        if (wr && byt) begin
            exp_be = addr[0] ? 2'b10 : 2'b01;
            exp_wd = {wd[7:0], wd[7:0]};
        end
        seen = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_byte = byt;
        mem_address = addr; mem_wdata = wd;
        for (int c = 1; c <= n_strobe + 2; c++) begin
            @(negedge clk);
            if (c <= n_strobe) begin
                if (is_wr ? pmem_write : pmem_read) seen++;
                chk("strobe_op",    16'(is_wr ? pmem_write : pmem_read), 16'd1);
                chk("strobe_other", 16'(is_wr ? pmem_read : pmem_write), 16'd0);
                chk("pmem_address", pmem_address, exp_addr);
                chk("byte_enable",  16'(pmem_byte_enable), 16'(exp_be));
                if (is_wr) chk("pmem_wdata", pmem_wdata, exp_wd);
                chk("resp_early",   16'(mem_resp), 16'd0);
                if (c == delay) begin
                    pmem_resp = 1'b1; pmem_rdata = rdv;
                end else begin
                    if (!held) pmem_resp = 1'b0;
                    pmem_rdata = 16'($urandom);
                end
            end else if (c == n_strobe + 1) begin
                if (!is_wr) model_rdata = answered ? rdv : 16'h0000;
                chk("strobe_count", 16'(seen), 16'(n_strobe));
                chk("mem_resp",     16'(mem_resp), 16'd1);
                chk("mem_error",    16'(mem_error), 16'(!answered));
                chk("strobes_off",  16'({pmem_read, pmem_write}), 16'd0);
                chk("mem_rdata",    mem_rdata, model_rdata);
                mem_read = 1'b0; mem_write = 1'b0;
            end else begin
                chk("resp_pulse",  16'(mem_resp), 16'd0);
                chk("error_pulse", 16'(mem_error), 16'd0);
                chk("idle_strobe", 16'({pmem_read, pmem_write}), 16'd0);
                pmem_resp = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte = 1'b0;
        mem_address = 16'h0000; mem_wdata = 16'h0000;
        pmem_rdata = 16'h0000; pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_strobes", 16'({pmem_read, pmem_write}), 16'd0);
        chk("rst_resp",    16'({mem_resp, mem_error}), 16'd0);
        chk("rst_rdata",   mem_rdata, 16'h0000);
        chk("rst_addr",    pmem_address, 16'h0000);
        chk("rst_be",      16'(pmem_byte_enable), 16'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_txn(1'b1, 1'b0, 1'b0, 16'h1235, 16'h0000, 16'hBEEF, 1, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 16'h0041, 16'h00A5, 16'h1111, 2, 1'b0);
        run_txn(1'b0, 1'b1, 1'b1, 16'h0040, 16'h00A5, 16'h2222, 1, 1'b1);
        run_txn(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h3333, 0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 16'h0203, 16'h0000, 16'hCAFE, TO, 1'b1);
        run_txn(1'b1, 1'b1, 1'b0, 16'h0305, 16'h5A5A, 16'h4444, 3, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 16'h0400, 16'h1234, 16'h5555, 0, 1'b0);

        // Reset asserted while a read is in flight.
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; mem_byte = 1'b0; mem_address = 16'h0ABC;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_strobe", 16'(pmem_read), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_strobe", 16'({pmem_read, pmem_write}), 16'd0);
        chk("async_rst_addr",   pmem_address, 16'h0000);
        model_rdata = 16'h0000;
        chk("async_rst_rdata",  mem_rdata, model_rdata);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_resp", 16'(mem_resp), 16'd0);
        end
        run_txn(1'b1, 1'b0, 1'b0, 16'h0777, 16'h0000, 16'h7777, 2, 1'b0);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic r, w;
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            run_txn(r, w, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, TO + 1)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
